// File: rtl/seq_div8by4.sv
// Sequential restoring divider, 8-bit dividend by 4-bit divisor.
// One quotient bit per clock, start/busy/done handshake.
module seq_div8by4 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] dividend,
   input  logic [3:0] divisor,
   output logic       busy,
   output logic       done,
   output logic [7:0] quotient,
   output logic [3:0] remainder,
   output logic       div_zero
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic [7:0] dq_q, dq_d;
   logic [3:0] pr_q, pr_d;
   logic [3:0] dvs_q, dvs_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic [7:0] quot_q, quot_d;
   logic [3:0] rem_q, rem_d;
   logic       dz_q, dz_d;

   logic       accept;
   logic [4:0] pr_sh;
   logic [3:0] pr_sub;
   logic       ge;
   logic [3:0] pr_nxt;
   logic [7:0] dq_nxt;

   always_comb begin
      // pr_sh is 5 bits so the compare sees the carry-out bit
      pr_sh  = {pr_q, dq_q[7]};
      ge     = (pr_sh >= {1'b0, dvs_q});
      pr_sub = pr_sh[3:0] - dvs_q;
      pr_nxt = ge ? pr_sub : pr_sh[3:0];
      dq_nxt = {dq_q[6:0], ge};
      accept = start && (state_q == S_IDLE || state_q == S_DONE);

      state_d = state_q;
      cnt_d   = cnt_q;
      dq_d    = dq_q;
      pr_d    = pr_q;
      dvs_d   = dvs_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dz_d    = dz_q;

      unique case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (accept) begin
               dq_d  = dividend;
               dvs_d = divisor;
               pr_d  = 4'd0;
               cnt_d = 3'd0;
               dz_d  = 1'b0;
               if (divisor == 4'd0) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  quot_d  = 8'hFF;
                  rem_d   = 4'd0;
                  dz_d    = 1'b1;
               end else begin
                  state_d = S_RUN;
                  busy_d  = 1'b1;
               end
            end
         end
         S_RUN: begin
            dq_d  = dq_nxt;
            pr_d  = pr_nxt;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               quot_d  = dq_nxt;
               rem_d   = pr_nxt;
            end else begin
               busy_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 3'd0;
         dq_q    <= 8'd0;
         pr_q    <= 4'd0;
         dvs_q   <= 4'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         quot_q  <= 8'd0;
         rem_q   <= 4'd0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dq_q    <= dq_d;
         pr_q    <= pr_d;
         dvs_q   <= dvs_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dz_q    <= dz_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign quotient  = quot_q;
   assign remainder = rem_q;
   assign div_zero  = dz_q;

endmodule

// File: tb/tb_seq_div8by4.sv
// Self-checking bench for seq_div8by4.
// Arithmetic reference model, directed and random operations.
module tb_seq_div8by4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] dividend = 8'd0;
   logic [3:0] divisor = 4'd0;
   logic       busy;
   logic       done;
   logic [7:0] quotient;
   logic [3:0] remainder;
   logic       div_zero;

   seq_div8by4 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [3:0] b;
      logic [7:0] q;
      logic [3:0] r;
      logic       dz;
   } exp_t;

   exp_t expq[$];
   exp_t last;
   exp_t zero_e;
   exp_t ce;
   int   n_cmp = 0;
   int   n_fail = 0;

   function automatic exp_t model(input logic [7:0] a, input logic [3:0] b);
      exp_t e;
      e.a = a;
      e.b = b;
      if (b == 4'd0) begin
         e.q  = 8'hFF;
         e.r  = 4'd0;
         e.dz = 1'b1;
      end else begin
         e.q  = a / {4'd0, b};
         e.r  = 4'(a % {4'd0, b});
         e.dz = 1'b0;
      end
      return e;
   endfunction

   task automatic chk(input string name, input int got, input int want);
      n_cmp++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
      end
   endtask

   // Checker: results on done cycles, held values otherwise
   always @(negedge clk) begin
      chk("busy_and_done", int'(busy & done), 0);
      if (done) begin
         if (expq.size() == 0) begin
            chk("unexpected_done", int'(done), 0);
         end else begin
            ce = expq.pop_front();
            chk("quotient", quotient, ce.q);
            chk("remainder", remainder, ce.r);
            chk("div_zero", div_zero, ce.dz);
            if (ce.b != 4'd0)
               chk("invariant",
                   int'((int'(quotient) * int'(ce.b) + int'(remainder)
                         == int'(ce.a)) && (remainder < ce.b)), 1);
            last = ce;
         end
      end else begin
         chk("hold_quotient", quotient, last.q);
         chk("hold_remainder", remainder, last.r);
         chk("hold_div_zero", div_zero, last.dz);
      end
   end

   task automatic start_op(input exp_t e);
      expq.push_back(e);
      dividend = e.a;
      divisor  = e.b;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (e.b != 4'd0) last.dz = 1'b0;
   endtask

   task automatic wait_done(input int lat, input int busy_want,
                            input logic [7:0] poke);
      int  n = 0;
      int  nb = 0;
      bit  got = 0;
      while (n < 20 && !got) begin
         @(negedge clk);
         n++;
         if (busy) nb++;
         if (done) got = 1;
         else if (poke != 8'd0 && n < 8) begin
            start    = poke[n];
            dividend = 8'd9;
            divisor  = 4'd2;
         end
      end
      chk("latency", got ? n : -1, lat);
      chk("busy_cycles", nb, busy_want);
   endtask

   task automatic directed(input logic [7:0] a, input logic [3:0] b,
                           input logic [7:0] q, input logic [3:0] r,
                           input logic dz);
      exp_t e;
      exp_t m;
      e.a = a; e.b = b; e.q = q; e.r = r; e.dz = dz;
      m = model(a, b);
      chk("model_pin_q", m.q, q);
      chk("model_pin_r", m.r, r);
      chk("model_pin_dz", m.dz, dz);
      start_op(e);
      wait_done(dz ? 1 : 9, dz ? 0 : 8, 8'd0);
      @(negedge clk);
   endtask

   initial begin
      exp_t e;
      zero_e = '{a: 8'd0, b: 4'd0, q: 8'd0, r: 4'd0, dz: 1'b0};
      last   = zero_e;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_quotient", quotient, 0);
      chk("rst_remainder", remainder, 0);
      chk("rst_div_zero", div_zero, 0);
      rst_n = 1'b1;
      @(negedge clk);

      directed(8'd200, 4'd7, 8'd28, 4'd4, 1'b0);
      directed(8'd255, 4'd1, 8'd255, 4'd0, 1'b0);
      directed(8'd9, 4'd10, 8'd0, 4'd9, 1'b0);
      directed(8'd225, 4'd15, 8'd15, 4'd0, 1'b0);
      directed(8'd0, 4'd5, 8'd0, 4'd0, 1'b0);
      directed(8'd77, 4'd0, 8'hFF, 4'd0, 1'b1);
      directed(8'd77, 4'd11, 8'd7, 4'd0, 1'b0);

      // start pokes at cycles 3 and 5 of a run must be ignored
      e = '{a: 8'd100, b: 4'd3, q: 8'd33, r: 4'd1, dz: 1'b0};
      start_op(e);
      wait_done(9, 8, 8'b0010_1000);
      start = 1'b0;
      @(negedge clk);

      // start held high through DONE: second op with no idle cycle
      e = '{a: 8'd100, b: 4'd3, q: 8'd33, r: 4'd1, dz: 1'b0};
      expq.push_back(e);
      dividend = e.a;
      divisor  = e.b;
      start    = 1'b1;
      @(posedge clk);
      #1;
      last.dz  = 1'b0;
      dividend = 8'd200;
      divisor  = 4'd7;
      wait_done(9, 8, 8'd0);
      e = '{a: 8'd200, b: 4'd7, q: 8'd28, r: 4'd4, dz: 1'b0};
      expq.push_back(e);
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      chk("b2b_busy", busy, 1);
      wait_done(8, 7, 8'd0);
      @(negedge clk);

      // reset during iteration 4 aborts the run
      e = '{a: 8'd200, b: 4'd7, q: 8'd28, r: 4'd4, dz: 1'b0};
      start_op(e);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      expq.delete();
      last = zero_e;
      @(negedge clk);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_quotient", quotient, 0);
      chk("abort_remainder", remainder, 0);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      directed(8'd50, 4'd6, 8'd8, 4'd2, 1'b0);

      // exhaustive non-zero divisors, back-to-back
      for (int a = 0; a < 256; a++) begin
         for (int b = 1; b < 16; b++) begin
            start_op(model(8'(a), 4'(b)));
            wait_done(9, 8, 8'd0);
         end
      end
      @(negedge clk);

      // products of the 4x4 multiplier divide back to the other operand
      for (int a = 0; a < 16; a++) begin
         for (int b = 1; b < 16; b++) begin
            e = '{a: 8'(a * b), b: 4'(b), q: 8'(a), r: 4'd0, dz: 1'b0};
            start_op(e);
            wait_done(9, 8, 8'd0);
         end
      end
      @(negedge clk);

      // randomized operations with random gaps
      for (int i = 0; i < 400; i++) begin
         logic [7:0] ra;
         logic [3:0] rb;
         int         gap;
         ra  = 8'($urandom_range(0, 255));
         rb  = 4'($urandom_range(0, 15));
         gap = $urandom_range(0, 3);
         start_op(model(ra, rb));
         wait_done(rb == 4'd0 ? 1 : 9, rb == 4'd0 ? 0 : 8, 8'd0);
         repeat (gap) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      chk("queue_drained", expq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_div8by4.md
# seq_div8by4

Sequential restoring divider: an 8-bit unsigned dividend divided by a 4-bit unsigned divisor, producing an 8-bit quotient and a 4-bit remainder. It is the inverse companion of the 4x4 Dadda multiplier: a product from that multiplier, divided by either operand, returns the other operand with remainder 0. It resolves one quotient bit per clock, uses a start/busy/done handshake, and is shared by datapath blocks that need a division without a wide combinational array.

## Interface
- No parameters. Widths are fixed at 8-bit dividend and 4-bit divisor.
- clk  input  1  rising-edge clock, the only clock.
- rst_n  input  1  reset, synchronous and active-low.
- start  input  1  request; sampled only when the block can accept a new operation.
- dividend  input  8  unsigned dividend; captured on the accepting edge.
- divisor  input  4  unsigned divisor; captured on the accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; quotient, remainder and div_zero are valid in that cycle.
- quotient  output  8  result quotient; held until the next accepted start.
- remainder  output  4  result remainder; held until the next accepted start.
- div_zero  output  1  set on completion of a divide-by-zero operation; held like the results.

## Operation
- States:
  - IDLE
  - RUN: 8 iterations, bit counter 0..7
  - DONE: 1 cycle
- Accept: start=1 at a rising edge while in IDLE or DONE.
  - Capture dividend into the shift register and divisor into the divisor register.
  - Clear the 5-bit partial remainder to 0.
  - Clear div_zero.
- Accept with divisor != 0: go to RUN, counter = 0.
- Accept with divisor == 0: skip RUN and go directly to DONE.
  - quotient = 8'hFF, remainder = 4'h0, div_zero = 1.
- RUN iteration, restoring algorithm, MSB first:
  - pr = {pr[3:0], dq[7]}; dq shifts left by 1.
  - If pr >= {1'b0, divisor}: pr = pr - divisor and the shifted-in quotient bit is 1; otherwise the bit is 0.
  - Comparison and subtraction are 5 bits wide, unsigned. pr[4] is never 1 after an iteration.
- After iteration 7: the dq register holds the quotient and pr[3:0] holds the remainder; go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE unless a new start is accepted on that edge.
- Invariant for every non-zero divisor: quotient*divisor + remainder == dividend and remainder < divisor.
- start in RUN is ignored, not queued. Input changes during RUN have no effect.

## Timing
- Reset (rst_n=0 at an edge) forces:
  - state = IDLE
  - busy = 0, done = 0
  - quotient = 0, remainder = 0, div_zero = 0
  - internal registers = 0
- Reset mid-RUN aborts the operation: no done pulse and results read 0.
- Latency for a normal operation, with the accepting edge at E:
  - busy = 1 in the cycles after edges E through E+7.
  - Results become valid and done = 1 after edge E+8.
  - done is high in cycle 9, counting from the start edge.
- Latency for divide-by-zero: done = 1 after edge E, i.e. 1 cycle; busy never asserts.
- Back-to-back: start held high in the DONE cycle is accepted on that edge. Throughput is one operation per 9 cycles.
- busy and done are never high in the same cycle.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Normal: dividend=200, divisor=7, start pulse → done 9 cycles later with quotient=28, remainder=4, div_zero=0; busy high for exactly 8 cycles.
- Range edges:
  - 255/1 → q=255, r=0
  - 9/10 → q=0, r=9
  - 225/15 → q=15, r=0
  - 0/5 → q=0, r=0
- Divide-by-zero: 77/0 → done 1 cycle later with q=8'hFF, r=0, div_zero=1. A following 77/11 clears div_zero and gives q=7, r=0.
- Handshake:
  - start pulsed at cycles 3 and 5 of a 100/3 run is ignored; result is q=33, r=1.
  - start held through DONE launches a second operation with no IDLE cycle.
- Reset: rst_n=0 during iteration 4 → next cycle all outputs 0, state IDLE, no done pulse; a new 50/6 then gives q=8, r=2.
- Exhaustive: all 256×15 non-zero combinations, each checked against the invariant and against the 4x4 multiplier: multiply a×b, divide by b, expect q=a, r=0.
